// File: rtl/jtcps1_cpu_sdram_slot.sv
// SDRAM access slot for the 68000: turns ROM/RAM/VRAM chip selects into single-word
// SDRAM requests and returns data/ok. Define JTCPS1_ROMCACHE_EN for a 4-entry ROM read cache.
module jtcps1_cpu_sdram_slot #(
  parameter logic [21:0] RAM_OFFSET  = 22'h30_0000,
  parameter logic [21:0] VRAM_OFFSET = 22'h31_0000,
  parameter logic [21:0] ROM_OFFSET  = 22'h00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_cs,
  input  logic [20:0] rom_addr,
  input  logic        ram_cs,
  input  logic        vram_cs,
  input  logic [16:0] addr,
  input  logic        UDSWn,
  input  logic        LDSWn,
  input  logic [15:0] cpu_dout,
  output logic [15:0] rom_data,
  output logic        rom_ok,
  output logic [15:0] ram_data,
  output logic        ram_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  output logic        sdram_we,
  output logic [1:0]  sdram_wrmask,
  output logic [15:0] sdram_din,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [15:0] sdram_dout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, nxt;

  logic        ram_sel, cur_vram, rom_hit, ram_hit, need_ram, need_rom;
  logic        start, start_rom, start_we, cache_load, done;
  logic        tgt_rom, tgt_vram, rom_valid, ram_valid, ram_vram_l;
  logic [20:0] rom_addr_l, req_rom_addr;
  logic [16:0] ram_addr_l, req_ram_addr;
  logic [21:0] start_addr;
  logic        cache_hit;
  logic [15:0] cache_rd;

  assign ram_sel  = ram_cs | vram_cs;
  assign cur_vram = vram_cs & ~ram_cs;
  // ok is a live compare so it drops in the same cycle cs or the address moves
  assign rom_hit  = rom_valid && (rom_addr_l == rom_addr);
  assign ram_hit  = ram_valid && (ram_addr_l == addr) && (ram_vram_l == cur_vram);
  assign rom_ok   = rom_cs & rom_hit;
  assign ram_ok   = ram_sel & ram_hit;
  assign need_ram = ram_sel & ~ram_hit;
  assign need_rom = rom_cs & ~rom_hit & ~cache_hit;
  assign done     = sdram_rdy && (state == WAIT || (state == REQ && sdram_ack));
  assign start_we = ~start_rom & ~(UDSWn & LDSWn);
  assign start_addr = start_rom ? ROM_OFFSET + {1'b0, rom_addr}
                    : (cur_vram ? VRAM_OFFSET : RAM_OFFSET) + {5'd0, addr};

`ifdef JTCPS1_ROMCACHE_EN
  logic [3:0]  cache_vld;
  logic [18:0] cache_tag [4];
  logic [15:0] cache_dat [4];

  assign cache_hit = cache_vld[rom_addr[1:0]] && (cache_tag[rom_addr[1:0]] == rom_addr[20:2]);
  assign cache_rd  = cache_dat[rom_addr[1:0]];

  always_ff @(posedge clk) begin
    if (rst) cache_vld <= '0;
    else if (done && tgt_rom) cache_vld[req_rom_addr[1:0]] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (done && tgt_rom) begin
      cache_tag[req_rom_addr[1:0]] <= req_rom_addr[20:2];
      cache_dat[req_rom_addr[1:0]] <= sdram_dout;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_rd  = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    start      = 1'b0;
    start_rom  = 1'b0;
    cache_load = 1'b0;
    sdram_req  = 1'b0;
    case (state)
      IDLE: begin
        if (need_ram) begin
          start = 1'b1;
          nxt   = REQ;
        end else if (need_rom) begin
          start     = 1'b1;
          start_rom = 1'b1;
          nxt       = REQ;
        end else if (rom_cs && !rom_hit && cache_hit) begin
          cache_load = 1'b1;
        end
      end
      REQ: begin
        sdram_req = 1'b1;
        if (sdram_ack) nxt = sdram_rdy ? DONE : WAIT;
        else if (tgt_rom ? !rom_cs : !ram_sel) nxt = IDLE;
      end
      WAIT:    if (sdram_rdy) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_addr   <= '0;
      sdram_we     <= 1'b0;
      sdram_wrmask <= 2'b00;
      sdram_din    <= '0;
      rom_data     <= '0;
      ram_data     <= '0;
      rom_valid    <= 1'b0;
      ram_valid    <= 1'b0;
      tgt_rom      <= 1'b0;
      tgt_vram     <= 1'b0;
      ram_vram_l   <= 1'b0;
      rom_addr_l   <= '0;
      ram_addr_l   <= '0;
      req_rom_addr <= '0;
      req_ram_addr <= '0;
    end else begin
      // a released select forgets its result so the next CPU cycle is a fresh access
      if (!rom_cs)  rom_valid <= 1'b0;
      if (!ram_sel) ram_valid <= 1'b0;
      if (start) begin
        sdram_addr   <= start_addr;
        sdram_we     <= start_we;
        sdram_wrmask <= {UDSWn, LDSWn};
        sdram_din    <= cpu_dout;
        tgt_rom      <= start_rom;
        tgt_vram     <= cur_vram;
        req_rom_addr <= rom_addr;
        req_ram_addr <= addr;
      end
      if (cache_load) begin
        rom_data   <= cache_rd;
        rom_addr_l <= rom_addr;
        rom_valid  <= 1'b1;
      end
      if (done) begin
        if (tgt_rom) begin
          rom_data   <= sdram_dout;
          rom_addr_l <= req_rom_addr;
          rom_valid  <= rom_cs;
        end else begin
          if (!sdram_we) ram_data <= sdram_dout;
          ram_addr_l <= req_ram_addr;
          ram_vram_l <= tgt_vram;
          ram_valid  <= ram_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcps1_cpu_sdram_slot.sv
// Bench for jtcps1_cpu_sdram_slot: reactive SDRAM model, reference memory and
// expected-request queue, directed cases plus randomized CPU accesses.
module tb_jtcps1_cpu_sdram_slot;
  logic        clk = 1'b0, rst;
  logic        rom_cs, ram_cs, vram_cs, UDSWn, LDSWn;
  logic [20:0] rom_addr;
  logic [16:0] addr;
  logic [15:0] cpu_dout, rom_data, ram_data, sdram_din, sdram_dout;
  logic        rom_ok, ram_ok, sdram_req, sdram_we, sdram_ack, sdram_rdy;
  logic [21:0] sdram_addr;
  logic [1:0]  sdram_wrmask;

  jtcps1_cpu_sdram_slot dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr), .ram_cs(ram_cs),
    .vram_cs(vram_cs), .addr(addr), .UDSWn(UDSWn), .LDSWn(LDSWn), .cpu_dout(cpu_dout),
    .rom_data(rom_data), .rom_ok(rom_ok), .ram_data(ram_data), .ram_ok(ram_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_we(sdram_we),
    .sdram_wrmask(sdram_wrmask), .sdram_din(sdram_din), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [21:0] a; logic we; logic [1:0] m; logic [15:0] d; } req_t;
  req_t        exp_q[$];
  logic [21:0] order_q[$];
  logic [15:0] sd_mem  [logic [21:0]];
  logic [15:0] ref_mem [logic [21:0]];
  logic        bc_vld [4];
  logic [18:0] bc_tag [4];
  int fix_ack = -1, fix_rdy = -1, req_cyc = 0, rdy_cyc = 0, req_count = 0;
  logic [21:0] ca;
  logic        cwe;
  logic [1:0]  cm;
  logic [15:0] cd, got_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h3C5A;
  endfunction
  function automatic logic [15:0] ref_get(input logic [21:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction
  function automatic logic [15:0] sd_get(input logic [21:0] a);
    if (sd_mem.exists(a)) return sd_mem[a];
    return init_val(a);
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] m, input logic [15:0] d);
    logic [15:0] r;
    r = old;
    if (!m[1]) r[15:8] = d[15:8];
    if (!m[0]) r[7:0]  = d[7:0];
    return r;
  endfunction
  function automatic logic [21:0] map_addr(input int kind, input logic [20:0] a);
    if (kind == 0) return {1'b0, a};
    if (kind == 1) return 22'h300000 + {5'd0, a[16:0]};
    return 22'h310000 + {5'd0, a[16:0]};
  endfunction
  function automatic bit cache_hit_model(input logic [20:0] a);
`ifdef JTCPS1_ROMCACHE_EN
    return bc_vld[a[1:0]] && bc_tag[a[1:0]] == a[20:2];
`else
    return 1'b0;
`endif
  endfunction
  task automatic cache_fill(input logic [20:0] a);
    bc_vld[a[1:0]] = 1'b1;
    bc_tag[a[1:0]] = a[20:2];
  endtask

  // SDRAM controller model: ack after a delay, rdy later, performs masked writes
  task automatic give_rdy();
    if (cwe) sd_mem[ca] = merge(sd_get(ca), cm, cd);
    else     sdram_dout = sd_get(ca);
    sdram_rdy = 1'b1;
    rdy_cyc = cyc;
    order_q.push_back(ca);
  endtask

  initial begin
    int ad, rd;
    bit abandon;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
    forever begin
      @(negedge clk);
      if (rst || !sdram_req) continue;
      req_cyc = cyc; req_count++;
      ca = sdram_addr; cwe = sdram_we; cm = sdram_wrmask; cd = sdram_din;
      ad = (fix_ack >= 0) ? fix_ack : int'($urandom_range(0, 2));
      rd = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
      abandon = 1'b0;
      for (int i = 0; i < ad; i++) begin
        @(negedge clk);
        if (rst || !sdram_req) begin abandon = 1'b1; break; end
      end
      if (abandon) continue;
      sdram_ack = 1'b1;
      if (rd == 0) give_rdy();
      @(negedge clk);
      sdram_ack = 1'b0;
      if (sdram_rdy) begin sdram_rdy = 1'b0; if (exp_q.size() > 0) void'(exp_q.pop_front()); end
      if (rd > 0) begin
        for (int i = 1; i < rd; i++) begin
          @(negedge clk);
          if (rst) begin abandon = 1'b1; break; end
        end
        if (!abandon && !rst) begin
          give_rdy();
          @(negedge clk);
          sdram_rdy = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // per-cycle comparison against the expected request queue and reference memory
  always @(negedge clk) begin
    if (!rst) begin
      if (sdram_req) begin
        if (exp_q.size() == 0) chk("unexpected_req", {10'd0, sdram_addr}, 32'hFFFFFFFF);
        else begin
          chk("req_addr", sdram_addr, exp_q[0].a);
          chk("req_we", sdram_we, exp_q[0].we);
          if (exp_q[0].we) begin
            chk("req_mask", sdram_wrmask, exp_q[0].m);
            chk("req_din", sdram_din, exp_q[0].d);
          end
        end
      end
      if (!rom_cs) chk("rom_ok_without_cs", rom_ok, 0);
      if (!(ram_cs | vram_cs)) chk("ram_ok_without_cs", ram_ok, 0);
      if (rom_ok) chk("rom_data", rom_data, ref_get(map_addr(0, rom_addr)));
      if (ram_ok && UDSWn && LDSWn)
        chk("ram_data", ram_data, ref_get(map_addr((vram_cs && !ram_cs) ? 2 : 1, {4'd0, addr})));
    end
  end

  task automatic wait_sig(input int which, output bit got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((which == 0 && rom_ok) || (which == 1 && ram_ok) || (which == 2 && sdram_req) ||
          (which == 3 && exp_q.size() == 0)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic drop_all();
    @(posedge clk); #1;
    rom_cs = 0; ram_cs = 0; vram_cs = 0; UDSWn = 1; LDSWn = 1;
  endtask

  // one complete CPU access: kind 0=ROM 1=RAM 2=VRAM
  task automatic access(input int kind, input logic [20:0] a, input bit wr,
                        input logic [1:0] m, input logic [15:0] d, input int hold);
    logic [21:0] ea;
    bit hit, got;
    int cs_cyc, rc0;
    ea  = map_addr(kind, a);
    hit = (kind == 0) && cache_hit_model(a);
    if (!hit) exp_q.push_back('{ea, wr, m, d});
    @(posedge clk); #1;
    cs_cyc = cyc; rc0 = req_count;
    rom_cs = (kind == 0); ram_cs = (kind == 1); vram_cs = (kind == 2);
    rom_addr = a; addr = a[16:0];
    UDSWn = wr ? m[1] : 1'b1; LDSWn = wr ? m[0] : 1'b1; cpu_dout = d;
    wait_sig(kind == 0 ? 0 : 1, got);
    chk("ok_arrives", got, 1);
    if (got) begin
      got_data = (kind == 0) ? rom_data : ram_data;
      if (hit) begin
        chk("hit_latency", cyc, cs_cyc + 1);
        chk("hit_no_req", req_count, rc0);
      end else begin
        chk("req_latency", req_cyc, cs_cyc + 1);
        chk("ok_latency", cyc, rdy_cyc + 1);
      end
    end else exp_q.delete();
    if (wr) ref_mem[ea] = merge(ref_get(ea), m, d);
    if (kind == 0 && !hit) cache_fill(a);
    drop_all();
    repeat (hold) @(posedge clk);
  endtask

  initial begin
    bit got;
    logic [15:0] tmp;
    int rc0;
    for (int i = 0; i < 4; i++) begin bc_vld[i] = 1'b0; bc_tag[i] = '0; end
    rst = 1; rom_cs = 0; ram_cs = 0; vram_cs = 0; rom_addr = '0; addr = '0;
    UDSWn = 1; LDSWn = 1; cpu_dout = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", sdram_req, 0);     chk("rst_addr", sdram_addr, 0);
    chk("rst_we", sdram_we, 0);       chk("rst_mask", sdram_wrmask, 0);
    chk("rst_din", sdram_din, 0);     chk("rst_rom_ok", rom_ok, 0);
    chk("rst_ram_ok", ram_ok, 0);     chk("rst_rom_data", rom_data, 0);
    chk("rst_ram_data", ram_data, 0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);

    // ROM read with a known opcode in SDRAM
    sd_mem[22'h000100] = 16'h4E75; ref_mem[22'h000100] = 16'h4E75;
    fix_ack = 1; fix_rdy = 4;
    access(0, 21'h000100, 0, 2'b11, 16'h0, 1);
    chk("rom_lit_addr", ca, 22'h000100);
    chk("rom_lit_data", got_data, 16'h4E75);
    fix_ack = -1; fix_rdy = -1;

    // RAM upper-byte write, then read back
    access(1, 21'h0010, 1, 2'b01, 16'hABCD, 1);
    chk("wr_lit_addr", ca, 22'h300010); chk("wr_lit_we", cwe, 1);
    chk("wr_lit_mask", cm, 2'b01);      chk("wr_lit_din", cd, 16'hABCD);
    access(1, 21'h0010, 0, 2'b11, 16'h0, 0);
    tmp = init_val(22'h300010);
    chk("wr_readback", got_data, {8'hAB, tmp[7:0]});

    // VRAM top word, then address change while ok is high
    exp_q.push_back('{22'h32FFFF, 1'b0, 2'b11, 16'h0});
    @(posedge clk); #1 vram_cs = 1; addr = 17'h1FFFF;
    wait_sig(1, got);
    chk("vram_ok", got, 1); chk("vram_lit_addr", ca, 22'h32FFFF);
    exp_q.push_back('{22'h32FFFE, 1'b0, 2'b11, 16'h0});
    @(posedge clk); #1 addr = 17'h1FFFE;
    @(negedge clk);
    chk("ram_ok_drop_on_addr", ram_ok, 0);
    wait_sig(1, got);
    chk("vram_ok2", got, 1); chk("vram_lit_addr2", ca, 22'h32FFFE);
    drop_all();

    // ROM and RAM together: RAM first
    order_q.delete();
    exp_q.push_back('{22'h300020, 1'b0, 2'b11, 16'h0});
    exp_q.push_back('{22'h000030, 1'b0, 2'b11, 16'h0});
    @(posedge clk); #1 ram_cs = 1; addr = 17'h20; rom_cs = 1; rom_addr = 21'h30;
    wait_sig(1, got); chk("both_ram_ok", got, 1);
    wait_sig(0, got); chk("both_rom_ok", got, 1);
    chk("both_ram_still_ok", ram_ok, 1);
    chk("both_order_n", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("both_first_ram", order_q[0], 22'h300020);
      chk("both_second_rom", order_q[1], 22'h000030);
    end
    cache_fill(21'h30);
    drop_all();

    // cs dropped before ack: request withdrawn
    fix_ack = 10;
    exp_q.push_back('{22'h01ABC0, 1'b0, 2'b11, 16'h0});
    @(posedge clk); #1 rom_cs = 1; rom_addr = 21'h1ABC0;
    wait_sig(2, got); chk("drop_pre_req", got, 1);
    drop_all();
    @(negedge clk); @(negedge clk);
    chk("drop_pre_req_low", sdram_req, 0);
    exp_q.delete();
    repeat (12) @(posedge clk);

    // cs dropped after ack: transfer completes silently
    fix_ack = 0; fix_rdy = 5;
    exp_q.push_back('{22'h01ABCD, 1'b0, 2'b11, 16'h0});
    @(posedge clk); #1 rom_cs = 1; rom_addr = 21'h1ABCD;
    wait_sig(2, got); chk("drop_post_req", got, 1);
    drop_all();
    wait_sig(3, got); chk("drop_post_done", got, 1);
    repeat (3) begin @(negedge clk); chk("drop_post_no_ok", rom_ok, 0); end
    chk("drop_post_idle", sdram_req, 0);
    cache_fill(21'h1ABCD);

    // reset while waiting for rdy
    fix_ack = 0; fix_rdy = 8;
    exp_q.push_back('{22'h300040, 1'b0, 2'b11, 16'h0});
    @(posedge clk); #1 ram_cs = 1; addr = 17'h40;
    wait_sig(2, got); chk("rst_wait_req", got, 1);
    @(posedge clk); #1 rst = 1; ram_cs = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_wait_req_low", sdram_req, 0);
    chk("rst_wait_addr", sdram_addr, 0);
    chk("rst_wait_ram_ok", ram_ok, 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) bc_vld[i] = 1'b0;
    fix_ack = -1; fix_rdy = -1;
    repeat (12) @(posedge clk);

    // repeated ROM reads: cache hit when enabled, SDRAM every time otherwise
    access(0, 21'h000104, 0, 2'b11, 16'h0, 1);
    rc0 = req_count;
    access(0, 21'h000104, 0, 2'b11, 16'h0, 1);
`ifdef JTCPS1_ROMCACHE_EN
    chk("cache_second_no_req", req_count, rc0);
`else
    chk("nocache_second_req", req_count, rc0 + 1);
`endif
    rc0 = req_count;
    access(0, 21'h000204, 0, 2'b11, 16'h0, 1);
    chk("cache_conflict_miss", req_count, rc0 + 1);
    rc0 = req_count;
    access(0, 21'h000104, 0, 2'b11, 16'h0, 1);
    chk("cache_evicted_miss", req_count, rc0 + 1);

    // randomized CPU traffic
    for (int n = 0; n < 200; n++) begin
      int k;
      bit w;
      logic [20:0] a;
      logic [1:0] m;
      k = $urandom_range(0, 2);
      if (k == 0)      a = 21'h000800 + 21'($urandom_range(0, 15));
      else if (k == 1) a = 21'($urandom_range(0, 15));
      else             a = 21'h01FFF0 + 21'($urandom_range(0, 15));
      w = (k != 0) && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       m = 2'b00;
        1:       m = 2'b01;
        default: m = 2'b10;
      endcase
      access(k, a, w, w ? m : 2'b11, 16'($urandom), $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
